// File: rtl/hazard_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : hazard_pkg                                                   |
// | Purpose : Shared constants for the hazard/forwarding controller:       |
// |           FPU opcodes, forwarding-select encodings, FSM state codes    |
// |           and the helper that maps an FPU opcode to its extra E-stage  |
// |           occupancy (latency - 1).                                     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package hazard_pkg;

  // Forwarding select for E-stage operands
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  // FPU opcodes; odd codes are FPU operations
  localparam int unsigned FADD  = 1;
  localparam int unsigned FSUB  = 3;
  localparam int unsigned FMUL  = 5;
  localparam int unsigned FDIV  = 7;
  localparam int unsigned FSQRT = 9;
  localparam int unsigned FCVT  = 11;
  localparam int unsigned FLOOR = 13;

  // FPU occupancy FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Cycles an op holds E beyond the first one
  function automatic int unsigned fpu_extra(input int unsigned op,
                                            input int unsigned fdiv_lat,
                                            input int unsigned fsqrt_lat);
    if (op == FDIV)       return fdiv_lat - 1;
    else if (op == FSQRT) return fsqrt_lat - 1;
    else                  return 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_occ_ctr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fpu_occ_ctr                                                  |
// | Purpose : Tracks how long a multi-cycle FPU op keeps the E stage.      |
// |           IDLE arms the counter from 'extra'; BUSY counts down and     |
// |           releases the stall on the op's final E cycle.                |
// | Ports   : clk, rstn (sync, active-low), extra [CNTW] (in);             |
// |           fstall, busy (out)                                           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module fpu_occ_ctr
  import hazard_pkg::*;
#(
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [CNTW-1:0] extra,
  output logic            fstall,
  output logic            busy
);

  localparam logic [CNTW-1:0] ONE = CNTW'(1);

  logic [0:0]      state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (extra != '0) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = extra - ONE;
        end
      end
      ST_BUSY: begin
        if (cnt != '0) cnt_nxt   = cnt - ONE;
        else           state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Opcode is only looked at in IDLE; while BUSY the E reg is held anyway.
  always_comb begin
    fstall = 1'b0;
    busy   = 1'b0;
    if (rstn) begin
      fstall = ((state == ST_IDLE) && (extra != '0)) ||
               ((state == ST_BUSY) && (cnt != '0));
      busy   = (state == ST_BUSY);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : hazard_unit_param                                            |
// | Purpose : Hazard/forwarding controller for the 5-stage core. Produces  |
// |           stall/flush, forwarding selects, branch-operand hazards and  |
// |           multi-cycle FPU occupancy stalls from stage-tagged reg ids.  |
// | Ports   : in  clk, rstn, rx_ready, in_d, branch_d/e, bi_d/e, regtopc_d,|
// |               rs/rt_d/e/m, wreg_e/m/w, regwr_e/m/w, memreg_e/m,        |
// |               fpu_ctrl_e                                               |
// |           out stall_f/d/e, flush_e/m, fwd_a/b_d, fwd_a/b_e, fwd_a/b_m, |
// |               haz_d, haz_e, fpu_busy                                   |
// | Config  : HAZ_STATS_EN adds st_lw, st_jr, st_fpu, st_in saturating     |
// |           per-cause stall cycle counters.                              |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module hazard_unit_param
  import hazard_pkg::*;
#(
  parameter int REGW      = 6,
  parameter int ZERO_REG  = 0,
  parameter int FPUW      = 5,
  parameter int FDIV_LAT  = 3,
  parameter int FSQRT_LAT = 2,
  parameter int CNTW      = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rx_ready,
  input  logic            in_d,
  input  logic            branch_d,
  input  logic            branch_e,
  input  logic            bi_d,
  input  logic            bi_e,
  input  logic            regtopc_d,
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic [REGW-1:0] rs_e,
  input  logic [REGW-1:0] rt_e,
  input  logic [REGW-1:0] rs_m,
  input  logic [REGW-1:0] rt_m,
  input  logic [REGW-1:0] wreg_e,
  input  logic [REGW-1:0] wreg_m,
  input  logic [REGW-1:0] wreg_w,
  input  logic            regwr_e,
  input  logic            regwr_m,
  input  logic            regwr_w,
  input  logic            memreg_e,
  input  logic            memreg_m,
  input  logic [FPUW-1:0] fpu_ctrl_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            flush_e,
  output logic            flush_m,
  output logic            fwd_a_d,
  output logic            fwd_b_d,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            fwd_a_m,
  output logic            fwd_b_m,
  output logic            haz_d,
  output logic            haz_e,
  output logic            fpu_busy
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]     st_lw,
  output logic [31:0]     st_jr,
  output logic [31:0]     st_fpu,
  output logic [31:0]     st_in
`endif
);

  localparam logic [REGW-1:0] ZR = REGW'(ZERO_REG);

  // The zero register is never a producer, so it never matches.
  function automatic logic match(input logic [REGW-1:0] x,
                                 input logic [REGW-1:0] y,
                                 input logic            we);
    return we && (x == y) && (x != ZR);
  endfunction

  function automatic fwd_sel_t sel_e(input logic [REGW-1:0] src);
    if (match(src, wreg_m, regwr_m))      return FWD_M;
    else if (match(src, wreg_w, regwr_w)) return FWD_W;
    else                                  return FWD_RF;
  endfunction

  logic            lwstall, jrstall, install, fstall, occ_busy;
  logic            haz_d_raw, haz_e_raw;
  logic [CNTW-1:0] extra;

  assign extra = CNTW'(fpu_extra(32'(fpu_ctrl_e), FDIV_LAT, FSQRT_LAT));

  fpu_occ_ctr #(.CNTW(CNTW)) u_occ (
    .clk    (clk),
    .rstn   (rstn),
    .extra  (extra),
    .fstall (fstall),
    .busy   (occ_busy)
  );

  // Branches resolve their own load-use via haz_d, so lwstall ignores them.
  assign lwstall = memreg_e && (match(rs_d, wreg_e, 1'b1) || match(rt_d, wreg_e, 1'b1))
                   && !branch_d;
  assign jrstall = regtopc_d && (match(rs_d, wreg_e, regwr_e) || match(rs_d, wreg_m, memreg_m));
  assign install = in_d && !rx_ready;

  assign haz_d_raw = branch_d &&
    (match(rs_d, wreg_e, regwr_e) || match(rs_d, wreg_m, memreg_m) ||
     (!bi_d && (match(rt_d, wreg_e, regwr_e) || match(rt_d, wreg_m, memreg_m))));
  assign haz_e_raw = branch_e &&
    (match(rs_e, wreg_m, memreg_m) || (!bi_e && match(rt_e, wreg_m, memreg_m)));

  // Every output is held low while rstn is asserted.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    fwd_a_d  = 1'b0;
    fwd_b_d  = 1'b0;
    fwd_a_e  = FWD_RF;
    fwd_b_e  = FWD_RF;
    fwd_a_m  = 1'b0;
    fwd_b_m  = 1'b0;
    haz_d    = 1'b0;
    haz_e    = 1'b0;
    fpu_busy = 1'b0;
    if (rstn) begin
      stall_f  = lwstall || jrstall || fstall || install;
      stall_d  = lwstall || jrstall || fstall || install;
      stall_e  = fstall;
      flush_m  = fstall;
      // E is being held by the FPU; a bubble here would destroy that op.
      flush_e  = (lwstall || jrstall || install) && !fstall;
      fwd_a_d  = match(rs_d, wreg_m, regwr_m);
      fwd_b_d  = match(rt_d, wreg_m, regwr_m);
      fwd_a_e  = sel_e(rs_e);
      fwd_b_e  = sel_e(rt_e);
      fwd_a_m  = match(rs_m, wreg_w, regwr_w);
      fwd_b_m  = match(rt_m, wreg_w, regwr_w);
      haz_d    = haz_d_raw;
      haz_e    = haz_e_raw;
      fpu_busy = occ_busy || fstall;
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_lw  <= '0;
      st_jr  <= '0;
      st_fpu <= '0;
      st_in  <= '0;
    end else begin
      if (lwstall && (st_lw  != '1)) st_lw  <= st_lw  + 32'd1;
      if (jrstall && (st_jr  != '1)) st_jr  <= st_jr  + 32'd1;
      if (fstall  && (st_fpu != '1)) st_fpu <= st_fpu + 32'd1;
      if (install && (st_in  != '1)) st_in  <= st_in  + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_param.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_hazard_unit_param                                         |
// | Purpose : Self-checking bench for hazard_unit_param: per-cycle vector  |
// |           table with expected outputs through a scoreboard queue, plus |
// |           an rx_ready wait sequence of random length.                  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_hazard_unit_param;
  import hazard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, rx_ready, in_d, branch_d, branch_e, bi_d, bi_e, regtopc_d;
  logic [5:0] rs_d, rt_d, rs_e, rt_e, rs_m, rt_m, wreg_e, wreg_m, wreg_w;
  logic       regwr_e, regwr_m, regwr_w, memreg_e, memreg_m;
  logic [4:0] fpu_ctrl_e;
  logic       stall_f, stall_d, stall_e, flush_e, flush_m;
  logic       fwd_a_d, fwd_b_d, fwd_a_m, fwd_b_m, haz_d, haz_e, fpu_busy;
  logic [1:0] fwd_a_e, fwd_b_e;
`ifdef HAZ_STATS_EN
  logic [31:0] st_lw, st_jr, st_fpu, st_in;
`endif

  hazard_unit_param dut (
    .clk(clk), .rstn(rstn), .rx_ready(rx_ready), .in_d(in_d),
    .branch_d(branch_d), .branch_e(branch_e), .bi_d(bi_d), .bi_e(bi_e),
    .regtopc_d(regtopc_d),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e), .rs_m(rs_m), .rt_m(rt_m),
    .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
    .regwr_e(regwr_e), .regwr_m(regwr_m), .regwr_w(regwr_w),
    .memreg_e(memreg_e), .memreg_m(memreg_m), .fpu_ctrl_e(fpu_ctrl_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_e(flush_e), .flush_m(flush_m),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .fwd_a_m(fwd_a_m), .fwd_b_m(fwd_b_m),
    .haz_d(haz_d), .haz_e(haz_e), .fpu_busy(fpu_busy)
`ifdef HAZ_STATS_EN
    , .st_lw(st_lw), .st_jr(st_jr), .st_fpu(st_fpu), .st_in(st_in)
`endif
  );

  typedef struct packed {
    logic       rstn, rx_ready, in_d, branch_d, branch_e, bi_d, bi_e, regtopc_d;
    logic [5:0] rs_d, rt_d, rs_e, rt_e, rs_m, rt_m, wreg_e, wreg_m, wreg_w;
    logic       regwr_e, regwr_m, regwr_w, memreg_e, memreg_m;
    logic [4:0] fpu;
  } in_t;

  typedef struct packed {
    in_t         in;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[$];
  string       names[$];
  logic [15:0] exp_q[$];
  string       name_q[$];
  int          tests = 0;
  int          fails = 0;

  wire [15:0] act = {stall_f, stall_d, stall_e, flush_e, flush_m, fwd_a_d, fwd_b_d,
                     fwd_a_e, fwd_b_e, fwd_a_m, fwd_b_m, haz_d, haz_e, fpu_busy};

  function automatic logic [15:0] e(input logic sf, sd, se, fe, fm, fad, fbd,
                                    input logic [1:0] fae, fbe,
                                    input logic fam, fbm, hd, he, bz);
    return {sf, sd, se, fe, fm, fad, fbd, fae, fbe, fam, fbm, hd, he, bz};
  endfunction

  task automatic add(input string n, input in_t v, input logic [15:0] x);
    vec_t t;
    t.in  = v;
    t.exp = x;
    tbl.push_back(t);
    names.push_back(n);
  endtask

  task automatic drive(input in_t v);
    rstn = v.rstn; rx_ready = v.rx_ready; in_d = v.in_d;
    branch_d = v.branch_d; branch_e = v.branch_e; bi_d = v.bi_d; bi_e = v.bi_e;
    regtopc_d = v.regtopc_d;
    rs_d = v.rs_d; rt_d = v.rt_d; rs_e = v.rs_e; rt_e = v.rt_e; rs_m = v.rs_m; rt_m = v.rt_m;
    wreg_e = v.wreg_e; wreg_m = v.wreg_m; wreg_w = v.wreg_w;
    regwr_e = v.regwr_e; regwr_m = v.regwr_m; regwr_w = v.regwr_w;
    memreg_e = v.memreg_e; memreg_m = v.memreg_m; fpu_ctrl_e = v.fpu;
  endtask

  // Drive one cycle, queue its expectation, compare at the falling edge.
  task automatic cycle(input in_t v, input logic [15:0] x, input string n);
    logic [15:0] ex;
    string       nm;
    drive(v);
    exp_q.push_back(x);
    name_q.push_back(n);
    @(negedge clk);
    ex = exp_q.pop_front();
    nm = name_q.pop_front();
    tests++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, ex);
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] OP_FADD  = 5'(FADD);
  localparam logic [4:0] OP_FDIV  = 5'(FDIV);
  localparam logic [4:0] OP_FSQRT = 5'(FSQRT);

  in_t z, v;
  logic [15:0] ZE, STALL_IN, STALL_FPU, BUSY_ONLY;

  initial begin
    z = '0;
    z.rstn    = 1'b1;
    ZE        = '0;
    STALL_IN  = e(1,1,0,1,0, 0,0, 2'b00,2'b00, 0,0, 0,0, 0);
    STALL_FPU = e(1,1,1,0,1, 0,0, 2'b00,2'b00, 0,0, 0,0, 1);
    BUSY_ONLY = e(0,0,0,0,0, 0,0, 2'b00,2'b00, 0,0, 0,0, 1);

    v = z; v.rstn = 0; v.rs_e = 3; v.wreg_m = 3; v.regwr_m = 1; v.memreg_e = 1;
    v.rs_d = 5; v.wreg_e = 5; v.fpu = OP_FDIV;               add("reset_forces_0", v, ZE);
    add("idle", z, ZE);
    v = z; v.rs_e = 3; v.wreg_m = 3; v.regwr_m = 1; v.wreg_w = 3; v.regwr_w = 1;
    add("fwd_e_m_wins", v, e(0,0,0,0,0, 0,0, 2'b10,2'b00, 0,0, 0,0, 0));
    v = z; v.rs_e = 3; v.rt_e = 4; v.wreg_m = 3; v.regwr_m = 1; v.wreg_w = 4; v.regwr_w = 1;
    add("fwd_e_m_and_w", v, e(0,0,0,0,0, 0,0, 2'b10,2'b01, 0,0, 0,0, 0));
    v = z; v.wreg_m = 0; v.regwr_m = 1; v.wreg_w = 0; v.regwr_w = 1;
    add("fwd_e_zero_reg", v, ZE);
    v = z; v.rs_d = 7; v.rt_d = 8; v.wreg_m = 8; v.regwr_m = 1;
    v.rs_m = 9; v.rt_m = 9; v.wreg_w = 9; v.regwr_w = 1;
    add("fwd_d_and_m", v, e(0,0,0,0,0, 0,1, 2'b00,2'b00, 1,1, 0,0, 0));
    v = z; v.rs_e = 3; v.wreg_m = 3;                          add("fwd_e_no_we", v, ZE);
    v = z; v.memreg_e = 1; v.wreg_e = 5; v.regwr_e = 1; v.rs_d = 5;
    add("lw_stall", v, STALL_IN);
    v = z; v.memreg_e = 1; v.regwr_e = 1;                     add("lw_zero_reg", v, ZE);
    v = z; v.memreg_e = 1; v.wreg_e = 5; v.regwr_e = 1; v.rs_d = 5; v.branch_d = 1;
    add("lw_branch_hazd", v, e(0,0,0,0,0, 0,0, 2'b00,2'b00, 0,0, 1,0, 0));
    v = z; v.branch_d = 1; v.bi_d = 1; v.rs_d = 2; v.rt_d = 6; v.wreg_m = 6; v.memreg_m = 1;
    add("hazd_bi_rt_ignored", v, ZE);
    v.bi_d = 0;
    add("hazd_rt_load_m", v, e(0,0,0,0,0, 0,0, 2'b00,2'b00, 0,0, 1,0, 0));
    v = z; v.branch_e = 1; v.rt_e = 6; v.wreg_m = 6; v.memreg_m = 1; v.regwr_m = 1;
    add("haze_rt_load_m", v, e(0,0,0,0,0, 0,0, 2'b00,2'b10, 0,0, 0,1, 0));
    v.bi_e = 1;
    add("haze_bi", v, e(0,0,0,0,0, 0,0, 2'b00,2'b10, 0,0, 0,0, 0));
    v = z; v.regtopc_d = 1; v.rs_d = 31; v.wreg_e = 31; v.regwr_e = 1;
    add("jr_e_write", v, STALL_IN);
    v = z; v.regtopc_d = 1; v.rs_d = 31; v.wreg_m = 31; v.memreg_m = 1; v.regwr_m = 1;
    add("jr_m_load", v, e(1,1,0,1,0, 1,0, 2'b00,2'b00, 0,0, 0,0, 0));
    v = z; v.regtopc_d = 1; v.rs_d = 31; v.wreg_e = 31;       add("jr_no_we", v, ZE);
    v = z; v.in_d = 1;                                        add("in_wait_0", v, STALL_IN);
    add("in_wait_1", v, STALL_IN);
    v.rx_ready = 1;                                           add("in_ready", v, ZE);
    v = z; v.fpu = OP_FDIV;
    add("fdiv_c0", v, STALL_FPU);
    add("fdiv_c1", v, STALL_FPU);
    add("fdiv_c2", v, BUSY_ONLY);
    add("fdiv2_c0", v, STALL_FPU);
    add("fdiv2_c1", v, STALL_FPU);
    add("fdiv2_c2", v, BUSY_ONLY);
    v.fpu = OP_FSQRT;
    add("fsqrt_c0", v, STALL_FPU);
    add("fsqrt_c1", v, BUSY_ONLY);
    v.fpu = OP_FADD;
    add("fadd_c0", v, ZE);
    add("fadd_c1", v, ZE);
    v = z; v.fpu = OP_FDIV; v.memreg_e = 1; v.wreg_e = 5; v.rs_d = 5;
    add("fdiv_lw_noflush", v, STALL_FPU);
    v = z; v.fpu = OP_FDIV;                                   add("fdiv_busy", v, STALL_FPU);
    v.rstn = 0;                                               add("reset_mid_busy", v, ZE);
    v = z; v.fpu = OP_FADD;                                   add("fadd_after_rst", v, ZE);
    v = z; v.fpu = OP_FDIV;                                   add("fdiv3_c0", v, STALL_FPU);
    add("busy_ignores_op", z, STALL_FPU);
    add("busy_last", z, BUSY_ONLY);
    add("idle_end", z, ZE);

    drive(z);
    for (int i = 0; i < tbl.size(); i++) cycle(tbl[i].in, tbl[i].exp, names[i]);

    // UART wait of random length, released by rx_ready
    begin
      int n;
      n = $urandom_range(5, 2);
      v = z; v.in_d = 1;
      for (int k = 0; k < n; k++) cycle(v, STALL_IN, "rx_wait");
      v.rx_ready = 1;
      cycle(v, ZE, "rx_release");
`ifdef HAZ_STATS_EN
      tests++;
      if (st_in !== 32'(n)) begin
        fails++;
        $display("FAIL st_in: got %0d expected %0d", st_in, n);
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
